pipe_out_mem_mc: RTL
====================

Name: pipe_out_mem_mc

Overview:
- Parametrised multi-channel capture buffer for the pipe-out path, successor to the single-pair capture memory.
- Records NUM_CH channels of DATA_W-bit samples (e.g. Ia/II spindle rates) for DEPTH sample strobes after an arm pulse.
- Serialises the stored block as 16-bit words to the host pipe.
- Adds arm/re-arm, continuous mode and dropped-sample accounting; one clock domain, with capture paced by a sample strobe.

Parameters:
- NUM_CH, 2, number of channels captured per strobe.
- DATA_W, 32, bits per channel sample; must be a multiple of 16.
- DEPTH, 1024, samples per channel per capture block; power of two, ≥2.
- CONTINUOUS, 0, 1 = auto re-arm after readout completes; 0 = one-shot, wait for arm.

Ports:
- pipe_clk, in, 1, single clock for capture and readout.
- reset1, in, 1, asynchronous active-high reset.
- arm, in, 1, single-cycle pulse that starts a capture block.
- sample_en, in, 1, strobe: capture din this cycle.
- din, in, NUM_CH*DATA_W, channel c occupies bits [c*DATA_W +: DATA_W].
- pipe_out_read, in, 1, host read enable, one word per asserted cycle.
- pipe_out_data, out, 16, serialised word.
- pipe_out_valid, out, 1, block captured and available to read.
- pipe_out_complete, out, 1, full block has been read out (sticky).
- busy, out, 1, capture in progress.
- dropped_cnt, out, 16, strobes ignored while not capturing after the first arm; saturates at 0xFFFF.

Behaviour:
- Reset values: all outputs 0; state IDLE; all indices 0. Memory contents undefined.
- Constants: WPS = DATA_W/16; TOTAL = DEPTH*NUM_CH*WPS.
- States:
  - IDLE: arm → CAPTURE. Clears pipe_out_complete, wr_idx and rd_idx.
  - CAPTURE (busy=1): each sample_en writes all NUM_CH channels at wr_idx, then increments wr_idx. The write at wr_idx=DEPTH-1 → READY next cycle.
  - READY (pipe_out_valid=1): first pipe_out_read → READOUT; that read counts as word 0.
  - READOUT (pipe_out_valid=1): each pipe_out_read advances rd_idx. The read of word TOTAL-1 sets pipe_out_complete=1 and clears pipe_out_valid. Next state is CAPTURE if CONTINUOUS=1 (complete cleared on entry), otherwise IDLE.
- Readout order: sample-major, then channel, then 16-bit slice LS first. Word k = din slice (k mod WPS) of channel ((k/WPS) mod NUM_CH) of sample k/(WPS*NUM_CH).
- Read latency: pipe_out_data is registered and updates on the edge after the cycle pipe_out_read is sampled high. It holds its value when read is low or in any other state.
- pipe_out_read in IDLE or CAPTURE: ignored, no state change.
- Arm behaviour:
  - arm in CAPTURE, READY or READOUT: ignored.
  - arm and sample_en in the same IDLE cycle: arm wins; that sample is not stored, capture starts on the next strobe.
- dropped_cnt: increments on sample_en in READY or READOUT, and in IDLE after the first arm. Cleared only by reset.
- sample_en in the cycle of the transition to READY (i.e. the cycle after the last write) counts as dropped.
- reset1 mid-capture or mid-readout: immediate return to IDLE. Outputs at reset values; no partial block is readable.
- Memory: one array of DEPTH entries × NUM_CH*DATA_W bits. Written with wr_idx, read with rd_idx >> log2(NUM_CH*WPS) when NUM_CH*WPS is a power of two, else a divided counter set (sample/channel/slice counters). Implementation uses the counter set in all cases.

Decomposition:
- Shared package pipe_pkg: state encoding (IDLE, CAPTURE, READY, READOUT), PIPE_W=16, clog2 function.
- One sub-module, pipe_word_ser: a slice/channel/sample counter chain plus the registered 16-bit mux. It signals last_word.
- The top level holds the FSM, the memory and dropped_cnt.

Test Plan (NUM_CH=2, DATA_W=32, DEPTH=4, CONTINUOUS=0 unless noted):
- Arm, then 4 strobes with din = {ch1=0x1111_0000+i, ch0=0xAAAA_0000+i}, i=0..3 → busy high for 4 strobes, pipe_out_valid=1 after the 4th.
- Then 16 reads → 0x0000,0xAAAA,0x0000,0x1111,0x0001,0xAAAA,… ending 0x0003,0x1111. Complete=1 and valid=0 after the 16th.
- Reads during CAPTURE → pipe_out_data unchanged. Read high in non-consecutive cycles → order preserved, no word skipped.
- 3 extra strobes while READY → dropped_cnt=3. Arm during READY → ignored, block unchanged.
- Reset after 8 of 16 reads → all outputs 0, state IDLE. Re-arm and capture a new block → reads start at sample 0.
- CONTINUOUS=1: after the 16th read, busy=1 the next cycle. The next 4 strobes capture a new block; complete clears on CAPTURE entry.
- Arm and sample_en in the same cycle → that din is not stored; the first stored sample is the next strobe's din.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipe-out capture buffer.
// State encoding, pipe word width and a constant log2.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_READY,
    S_READOUT
  } state_e;

  localparam int PIPE_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_word_ser.sv
// Word serialiser: slice/channel/sample counter chain and
// a registered 16-bit output mux over the current memory row.
module pipe_word_ser
  import pipe_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int WPS   = DATA_W / PIPE_W,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = (NUM_CH > 1) ? clog2(NUM_CH) : 1,
  localparam int SW    = (WPS > 1) ? clog2(WPS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     adv_i,
  input  logic [NUM_CH*DATA_W-1:0] row_i,
  output logic [AW-1:0]            smp_o,
  output logic [PIPE_W-1:0]        data_o,
  output logic                     last_o
);

  logic [SW-1:0]     sl_q, sl_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [AW-1:0]     smp_q, smp_d;
  logic [PIPE_W-1:0] data_q, data_d;
  logic [PIPE_W-1:0] word;
  logic              last_sl, last_ch, last_smp;

  assign last_sl  = (sl_q == SW'(WPS - 1));
  assign last_ch  = (ch_q == CW'(NUM_CH - 1));
  assign last_smp = (smp_q == AW'(DEPTH - 1));

  // Pick the 16-bit slice addressed by the channel/slice counters.
  always_comb begin
    word = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < WPS; s++)
        if (ch_q == CW'(c) && sl_q == SW'(s))
          word = row_i[c*DATA_W + s*PIPE_W +: PIPE_W];
  end

  // Counter chain: slice fastest, then channel, then sample.
  always_comb begin
    sl_d   = sl_q;
    ch_d   = ch_q;
    smp_d  = smp_q;
    data_d = data_q;
    if (clr_i) begin
      sl_d  = '0;
      ch_d  = '0;
      smp_d = '0;
    end else if (adv_i) begin
      data_d = word;
      if (last_sl) begin
        sl_d = '0;
        if (last_ch) begin
          ch_d  = '0;
          smp_d = smp_q + AW'(1);
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end else begin
        sl_d = sl_q + SW'(1);
      end
    end
  end

  // Counter and output word registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sl_q   <= '0;
      ch_q   <= '0;
      smp_q  <= '0;
      data_q <= '0;
    end else begin
      sl_q   <= sl_d;
      ch_q   <= ch_d;
      smp_q  <= smp_d;
      data_q <= data_d;
    end
  end

  assign smp_o  = smp_q;
  assign data_o = data_q;
  assign last_o = last_sl & last_ch & last_smp;

endmodule

// File: rtl/pipe_out_mem_mc.sv
// Multi-channel capture buffer for the pipe-out path:
// arm/capture FSM, sample memory and dropped-strobe counter.
module pipe_out_mem_mc
  import pipe_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int CONTINUOUS = 0,
  localparam int AW        = clog2(DEPTH),
  localparam int ROW_W     = NUM_CH * DATA_W
) (
  input  logic              pipe_clk,
  input  logic              reset1,
  input  logic              arm,
  input  logic              sample_en,
  input  logic [ROW_W-1:0]  din,
  input  logic              pipe_out_read,
  output logic [PIPE_W-1:0] pipe_out_data,
  output logic              pipe_out_valid,
  output logic              pipe_out_complete,
  output logic              busy,
  output logic [15:0]       dropped_cnt
);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic            armed_q, armed_d;
  logic            cmp_q, cmp_d;
  logic [15:0]     drop_q, drop_d;
  logic            clr, adv, we, drop_inc, last_word;
  logic [AW-1:0]   rd_smp;
  logic [ROW_W-1:0] mem_q [DEPTH];

  // Next-state, memory write and drop accounting.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    armed_d  = armed_q;
    cmp_d    = cmp_q;
    drop_d   = drop_q;
    clr      = 1'b0;
    adv      = 1'b0;
    we       = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        drop_inc = sample_en & armed_q;
        if (arm) begin
          state_d = S_CAPTURE;
          cmp_d   = 1'b0;
          wr_d    = '0;
          clr     = 1'b1;
          armed_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        cmp_d = 1'b0;
        if (sample_en) begin
          we   = 1'b1;
          wr_d = wr_q + AW'(1);
          if (wr_q == AW'(DEPTH - 1))
            state_d = S_READY;
        end
      end
      S_READY: begin
        drop_inc = sample_en;
        if (pipe_out_read) begin
          adv     = 1'b1;
          state_d = S_READOUT;
        end
      end
      S_READOUT: begin
        drop_inc = sample_en;
        if (pipe_out_read) begin
          adv = 1'b1;
          if (last_word) begin
            cmp_d   = 1'b1;
            wr_d    = '0;
            state_d = (CONTINUOUS != 0) ? S_CAPTURE : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (drop_inc && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  // Control state registers.
  always_ff @(posedge pipe_clk or posedge reset1) begin
    if (reset1) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      armed_q <= 1'b0;
      cmp_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      armed_q <= armed_d;
      cmp_q   <= cmp_d;
      drop_q  <= drop_d;
    end
  end

  // Sample memory: one row holds every channel of a strobe.
  always_ff @(posedge pipe_clk) begin
    if (we) mem_q[wr_q] <= din;
  end

  pipe_word_ser #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ser (
    .clk_i  (pipe_clk),
    .rst_i  (reset1),
    .clr_i  (clr),
    .adv_i  (adv),
    .row_i  (mem_q[rd_smp]),
    .smp_o  (rd_smp),
    .data_o (pipe_out_data),
    .last_o (last_word)
  );

  assign busy              = (state_q == S_CAPTURE);
  assign pipe_out_valid    = (state_q == S_READY) || (state_q == S_READOUT);
  assign pipe_out_complete = cmp_q;
  assign dropped_cnt       = drop_q;

endmodule
